// File: rtl/cavlc_pkg.sv
// Shared types and constants for the CAVLC bitstream write path.
package cavlc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  localparam int unsigned REQ_COEFF_TOKEN = 0;
  localparam int unsigned REQ_T1_SIGNS    = 1;
  localparam int unsigned REQ_LEVEL       = 2;
  localparam int unsigned REQ_TOTAL_ZEROS = 3;
  localparam int unsigned REQ_RUN_BEFORE  = 4;

  localparam int unsigned CAVLC_CODE_W = 16;
  localparam int unsigned CAVLC_LEN_W  = 5;

endpackage

// File: rtl/cavlc_code_shifter.sv
// Parallel-load codeword register that emits its bits MSB-first, with a
// remaining-bit counter.
module cavlc_code_shifter
  import cavlc_pkg::*;
#(
  parameter int unsigned CODE_W = CAVLC_CODE_W,
  parameter int unsigned LEN_W  = CAVLC_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [CODE_W-1:0] code,
  input  logic [LEN_W-1:0]  len,
  input  logic              shift_en,
  output logic              bit_out,
  output logic              last_bit
);

  logic [CODE_W-1:0] sr_q;
  logic [LEN_W-1:0]  rem_q;

  // Left-aligning on load drops code bits above len and keeps the current bit at the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      rem_q <= '0;
    end else if (load) begin
      sr_q  <= code << (CODE_W - int'(len));
      rem_q <= len;
    end else if (shift_en && (rem_q != '0)) begin
      sr_q  <= sr_q << 1;
      rem_q <= rem_q - 1'b1;
    end
  end

  assign bit_out  = sr_q[CODE_W-1];
  assign last_bit = (rem_q == LEN_W'(1));

endmodule

// File: rtl/cavlc_bitstream_sequencer.sv
// Services the per-block syntax-element encoders in index order and serialises
// their codewords into the 1-bit bitstream FIFO.
module cavlc_bitstream_sequencer
  import cavlc_pkg::*;
#(
  parameter int unsigned NUM_REQ = 5,
  parameter int unsigned CODE_W  = CAVLC_CODE_W,
  parameter int unsigned LEN_W   = CAVLC_LEN_W,
  parameter int unsigned CNT_W   = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      blk_start,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*CODE_W-1:0] req_code,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_w_en,
  output logic                      fifo_data_in,
  output logic                      busy,
  output logic                      blk_done,
  output logic [CNT_W-1:0]          bit_count
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               last_q;
  logic [CNT_W-1:0]   bit_count_q;

  logic               sel_valid;
  logic               sel_last;
  logic [CODE_W-1:0]  sel_code;
  logic [LEN_W-1:0]   sel_len;
  logic [LEN_W-1:0]   eff_len;
  logic               accept;
  logic               wr;
  logic               cur_bit;
  logic               last_bit;
  logic               is_last_idx;

  always_comb begin
    sel_valid = req_valid[idx_q];
    sel_last  = req_last[idx_q];
    sel_code  = req_code[idx_q*CODE_W +: CODE_W];
    sel_len   = req_len[idx_q*LEN_W +: LEN_W];
    if (int'(sel_len) > int'(CODE_W)) eff_len = LEN_W'(CODE_W);
    else                              eff_len = sel_len;
  end

  assign accept      = (state_q == LOAD) && sel_valid;
  assign wr          = (state_q == SHIFT) && !fifo_full;
  assign is_last_idx = (idx_q == IDX_W'(NUM_REQ - 1));

  cavlc_code_shifter #(
    .CODE_W (CODE_W),
    .LEN_W  (LEN_W)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .code     (sel_code),
    .len      (eff_len),
    .shift_en (wr),
    .bit_out  (cur_bit),
    .last_bit (last_bit)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (blk_start) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          if (eff_len != '0) begin
            state_d = SHIFT;
          end else if (sel_last) begin
            if (is_last_idx) state_d = DONE;
            else             idx_d   = idx_q + 1'b1;
          end
        end
      end
      SHIFT: begin
        if (wr && last_bit) begin
          if (!last_q)          state_d = LOAD;
          else if (is_last_idx) state_d = DONE;
          else begin
            state_d = LOAD;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready        = '0;
    req_ready[idx_q] = accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      last_q      <= 1'b0;
      bit_count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) last_q <= sel_last;
      if ((state_q == IDLE) && blk_start)  bit_count_q <= '0;
      else if (wr && (bit_count_q != '1)) bit_count_q <= bit_count_q + 1'b1;
    end
  end

  assign fifo_w_en    = wr;
  assign fifo_data_in = wr & cur_bit;
  assign busy         = (state_q != IDLE);
  assign blk_done     = (state_q == DONE);
  assign bit_count    = bit_count_q;

endmodule

// File: tb/tb_cavlc_bitstream_sequencer.sv
// Directed bench for cavlc_bitstream_sequencer: table of single-codeword blocks
// plus hand sequences for multi-codeword requesters and mid-block reset.
module tb_cavlc_bitstream_sequencer;

  localparam int NR = 5;
  localparam int CW = 16;
  localparam int LW = 5;
  localparam int CN = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              blk_start;
  logic [NR-1:0]     req_valid;
  logic [NR*CW-1:0]  req_code;
  logic [NR*LW-1:0]  req_len;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic              fifo_full;
  logic              fifo_w_en;
  logic              fifo_data_in;
  logic              busy;
  logic              blk_done;
  logic [CN-1:0]     bit_count;

  cavlc_bitstream_sequencer #(
    .NUM_REQ (NR),
    .CODE_W  (CW),
    .LEN_W   (LW),
    .CNT_W   (CN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .blk_start    (blk_start),
    .req_valid    (req_valid),
    .req_code     (req_code),
    .req_len      (req_len),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_w_en    (fifo_w_en),
    .fifo_data_in (fifo_data_in),
    .busy         (busy),
    .blk_done     (blk_done),
    .bit_count    (bit_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Per-requester codeword lists; the final entry of each list carries last=1.
  logic [CW-1:0] cw_code [NR][4];
  logic [LW-1:0] cw_len  [NR][4];
  int            cw_cnt  [NR];
  int            ptr     [NR];
  logic [63:0]   full_mask;
  logic [63:0]   start_mask;

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      if (ptr[i] < cw_cnt[i]) begin
        req_valid[i]             = 1'b1;
        req_code[i*CW +: CW]     = cw_code[i][ptr[i]];
        req_len[i*LW +: LW]      = cw_len[i][ptr[i]];
        req_last[i]              = (ptr[i] == cw_cnt[i] - 1);
      end else begin
        req_valid[i]             = 1'b0;
        req_code[i*CW +: CW]     = '0;
        req_len[i*LW +: LW]      = '0;
        req_last[i]              = 1'b0;
      end
    end
  endtask

  task automatic run_block(input string tag, input logic [63:0] exp_val, input int exp_n,
                           input logic [63:0] exp_wmask, input int exp_done);
    logic [63:0] got_val;
    logic [63:0] wmask;
    int          nb;
    int          done_c;
    int          rdy [NR];
    bit          viol;
    got_val = '0;
    wmask   = '0;
    nb      = 0;
    done_c  = -1;
    viol    = 1'b0;
    for (int i = 0; i < NR; i++) begin
      ptr[i] = 0;
      rdy[i] = 0;
    end
    for (int c = 0; c < 200 && done_c < 0; c++) begin
      @(posedge clk); #1;
      blk_start = (c < 64) ? start_mask[c] : 1'b0;
      fifo_full = (c < 64) ? full_mask[c]  : 1'b0;
      drive_reqs();
      @(negedge clk);
      if (fifo_w_en) begin
        got_val = {got_val[62:0], fifo_data_in};
        nb++;
        if (c < 64) wmask[c] = 1'b1;
        if (fifo_full) viol = 1'b1;
      end else if (fifo_data_in) begin
        viol = 1'b1;
      end
      if ($countones(req_ready) > 1) viol = 1'b1;
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i]) begin
          rdy[i]++;
          ptr[i]++;
        end
      end
      if (blk_done) begin
        done_c = c;
        chk({tag, "_count_at_done"}, 64'(bit_count), 64'(exp_n));
      end
    end
    chk({tag, "_done_cycle"}, 64'(done_c), 64'(exp_done));
    chk({tag, "_bits"}, got_val, exp_val);
    chk({tag, "_nbits"}, 64'(nb), 64'(exp_n));
    chk({tag, "_write_cycles"}, wmask, exp_wmask);
    chk({tag, "_protocol"}, 64'(viol), 64'd0);
    for (int i = 0; i < NR; i++)
      chk($sformatf("%s_ready%0d_pulses", tag, i), 64'(rdy[i]), 64'(cw_cnt[i]));
    @(posedge clk); #1;
    blk_start = 1'b0;
    fifo_full = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk({tag, "_idle_after"}, {62'd0, busy, blk_done}, 64'd0);
    chk({tag, "_count_hold"}, 64'(bit_count), 64'(exp_n));
  endtask

  typedef struct {
    string       name;
    logic [CW-1:0] code [NR];
    logic [LW-1:0] len  [NR];
    logic [63:0] full;
    logic [63:0] start;
    logic [63:0] exp_val;
    int          exp_n;
    logic [63:0] exp_wmask;
    int          exp_done;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{"basic",     '{16'h0005, 16'h0, 16'h0, 16'h0, 16'h0}, '{5'd3, 5'd0, 5'd0, 5'd0, 5'd0},
               64'h0,   64'h1,   64'h5,    3,  64'h1C,    9};
    tbl[1] = '{"stall",     '{16'h0005, 16'h0, 16'h0, 16'h0, 16'h0}, '{5'd3, 5'd0, 5'd0, 5'd0, 5'd0},
               64'h78,  64'h1,   64'h5,    3,  64'h184,   13};
    tbl[2] = '{"len_clamp", '{16'hA5F0, 16'h0, 16'h0, 16'h0, 16'h0}, '{5'd20, 5'd0, 5'd0, 5'd0, 5'd0},
               64'h0,   64'h1,   64'hA5F0, 16, 64'h3FFFC, 22};
    tbl[3] = '{"all_zero",  '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0},    '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0},
               64'h0,   64'h1,   64'h0,    0,  64'h0,     6};
    tbl[4] = '{"mixed",     '{16'h0006, 16'h0001, 16'h0, 16'h0003, 16'h0002}, '{5'd2, 5'd1, 5'd0, 5'd3, 5'd2},
               64'h0,   64'h1,   64'hAE,   8,  64'h372C,  14};
    tbl[5] = '{"mixed_stall", '{16'h0006, 16'h0001, 16'h0, 16'h0003, 16'h0002}, '{5'd2, 5'd1, 5'd0, 5'd3, 5'd2},
               64'h230, 64'h1,   64'hAE,   8,  64'hDC4C,  16};
    tbl[6] = '{"start_busy", '{16'h0005, 16'h0, 16'h0, 16'h0, 16'h0}, '{5'd3, 5'd0, 5'd0, 5'd0, 5'd0},
               64'h0,   64'h209, 64'h5,    3,  64'h1C,    9};

    rst        = 1'b1;
    blk_start  = 1'b0;
    req_valid  = '0;
    req_code   = '0;
    req_len    = '0;
    req_last   = '0;
    fifo_full  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {45'd0, req_ready, fifo_w_en, fifo_data_in, busy, blk_done, bit_count}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < NR; i++) begin
        cw_code[i][0] = tbl[v].code[i];
        cw_len[i][0]  = tbl[v].len[i];
        cw_cnt[i]     = 1;
      end
      full_mask  = tbl[v].full;
      start_mask = tbl[v].start;
      run_block(tbl[v].name, tbl[v].exp_val, tbl[v].exp_n, tbl[v].exp_wmask, tbl[v].exp_done);
    end

    // Requester 1 sends a zero-length non-final word; requester 2 sends four words.
    for (int i = 0; i < NR; i++) begin
      cw_code[i][0] = '0;
      cw_len[i][0]  = '0;
      cw_cnt[i]     = 1;
    end
    cw_cnt[1]     = 2;
    cw_code[1][1] = '0;   cw_len[1][1] = 5'd0;
    cw_cnt[2]     = 4;
    cw_code[2][0] = 16'h0001; cw_len[2][0] = 5'd1;
    cw_code[2][1] = 16'h0001; cw_len[2][1] = 5'd2;
    cw_code[2][2] = 16'h0001; cw_len[2][2] = 5'd3;
    cw_code[2][3] = 16'h0003; cw_len[2][3] = 5'd2;
    full_mask  = 64'h0;
    start_mask = 64'h1;
    run_block("multi", 64'hA7, 8, 64'hDDA0, 18);

    // Reset while the shifter still holds two bits of 1011.
    for (int i = 0; i < NR; i++) begin
      cw_code[i][0] = '0;
      cw_len[i][0]  = '0;
      cw_cnt[i]     = 1;
      ptr[i]        = 0;
    end
    cw_code[0][0] = 16'h000B;
    cw_len[0][0]  = 5'd4;
    @(posedge clk); #1;
    blk_start = 1'b1;
    drive_reqs();
    @(posedge clk); #1;
    blk_start = 1'b0;
    @(negedge clk);
    chk("rst_seq_ready", 64'(req_ready), 64'h1);
    ptr[0] = 1;
    @(posedge clk); #1;
    drive_reqs();
    @(negedge clk);
    chk("rst_seq_bit0", {62'd0, fifo_w_en, fifo_data_in}, 64'h3);
    @(posedge clk);
    @(negedge clk);
    chk("rst_seq_bit1", {62'd0, fifo_w_en, fifo_data_in}, 64'h2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_seq_bit2", {62'd0, fifo_w_en, fifo_data_in}, 64'h3);
    @(posedge clk); #1;
    rst = 1'b0;
    ptr[0] = 0;
    drive_reqs();
    @(negedge clk);
    chk("rst_seq_outputs", {45'd0, req_ready, fifo_w_en, fifo_data_in, busy, blk_done, bit_count}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_seq_stays_idle", {62'd0, busy, fifo_w_en}, 64'd0);
    req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cavlc_bitstream_sequencer.md
# cavlc_bitstream_sequencer

Write-side controller for the CAVLC 1-bit bitstream FIFO. It services the per-block syntax-element encoders in fixed H.264 order: coeff_token, trailing-ones signs, levels, total_zeros, run_before. It accepts variable-length codewords from each encoder through a valid/ready handshake and serialises them MSB-first, one bit per cycle, into the FIFO write port, stalling on FIFO full. It signals block completion and reports the block's bit count to the slice-level controller.

## Interface
Parameters:
- NUM_REQ, 5, number of syntax-element requesters, serviced in index order
- CODE_W, 16, maximum codeword length in bits
- LEN_W, 5, width of a length field
- CNT_W, 12, width of bit_count

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- blk_start  in  1  start one block; accepted only in IDLE
- req_valid  in  NUM_REQ  codeword valid, one bit per requester
- req_code  in  NUM_REQ*CODE_W  codeword, right-aligned; slice i is [i*CODE_W +: CODE_W]
- req_len  in  NUM_REQ*LEN_W  codeword length 0..CODE_W; slice i is [i*LEN_W +: LEN_W]
- req_last  in  NUM_REQ  this codeword is the requester's final one for the block
- req_ready  out  NUM_REQ  one-hot single-cycle accept pulse
- fifo_full  in  1  FIFO full flag
- fifo_w_en  out  1  FIFO write enable
- fifo_data_in  out  1  bit to write
- busy  out  1  high in any state other than IDLE
- blk_done  out  1  one-cycle pulse at block end
- bit_count  out  CNT_W  bits written in the current or last block

## Operation
- States:
  - IDLE: blk_start=1 moves to LOAD, sets idx=0 and clears bit_count.
  - LOAD: if req_valid[idx]=1, assert req_ready[idx] and capture code, effective length and last in the same cycle.
    - Captured length > 0: go to SHIFT.
    - Captured length = 0 and last=1: advance. idx<NUM_REQ-1 increments idx and stays in LOAD; idx=NUM_REQ-1 goes to DONE.
    - Captured length = 0 and last=0: stay in LOAD, same idx.
    - req_valid[idx]=0: wait in LOAD.
  - SHIFT: when fifo_full=0, write one bit. fifo_w_en=1, fifo_data_in = code[rem-1], rem decrements, bit_count increments.
    - On the write where rem=1: if captured last=0, go to LOAD with the same idx. If last=1, advance as in LOAD.
  - DONE: blk_done=1 for one cycle, then IDLE.
- Length rule: effective length = min(req_len, CODE_W). Bits above the effective length in the code are ignored.
- fifo_w_en is never asserted while fifo_full=1. fifo_data_in is don't-care when fifo_w_en=0 and is driven to 0.
- Requesters other than idx never see req_ready and their inputs are ignored.
- blk_start outside IDLE is ignored.
- bit_count saturates at its maximum value and holds after DONE until the next accepted blk_start.

## Timing
- Reset: the state is IDLE on the cycle after rst is sampled high. All outputs are 0: req_ready, fifo_w_en, fifo_data_in, busy, blk_done, bit_count.
  - Reset mid-block discards the in-flight codeword. Bits already written stay in the FIFO.
- Start latency: blk_start in cycle 0 gives LOAD in cycle 1. The earliest req_ready is in cycle 1 and the first fifo_w_en in cycle 2.
- Throughput: a codeword of length L costs 1 LOAD cycle plus L write cycles plus stall cycles.
- fifo_w_en and fifo_data_in are combinational from the state, rem, the shift register and fifo_full. All other outputs are registered or decoded from registered state.
- All-zero-length block: blk_start in cycle 0 gives LOAD in cycles 1..NUM_REQ, with blk_done in cycle NUM_REQ+1.
- fifo_full may toggle on any cycle. A stall holds rem and the current bit unchanged.

## Structure
- Shared package cavlc_pkg:
  - state enum: IDLE, LOAD, SHIFT, DONE
  - requester index constants: REQ_COEFF_TOKEN=0, REQ_T1_SIGNS=1, REQ_LEVEL=2, REQ_TOTAL_ZEROS=3, REQ_RUN_BEFORE=4
  - CODE_W and LEN_W defaults
- One sub-module, cavlc_code_shifter:
  - parallel-load codeword register plus remaining-bit counter
  - inputs load and shift_en
  - outputs the current bit and last_bit (rem=1)
- The top level holds the FSM, the idx counter, the request mux and bit_count.

## Test plan
- blk_start; req0 code=0b101 len=3 last=1; req1..4 len=0 last=1 -> fifo_w_en high cycles 2..4, bits 1,0,1; blk_done in cycle 9; bit_count=3.
- Same block, fifo_full=1 during cycles 3..6 -> no writes in cycles 3..6; bit sequence 1,0,1 intact; blk_done 4 cycles later; bit_count=3.
- req2 sends three codewords without last: 0b1 len1, 0b01 len2, 0b001 len3; then a fourth with last=1 -> FIFO receives 1,01,001 in order; req_ready[2] pulses 4 times.
- req0 len=20 with code=16'hA5F0 -> exactly 16 bits written, 1010010111110000; bit_count=16.
- rst asserted in SHIFT with rem=2 -> next cycle all outputs 0 and IDLE; blk_start issued while busy is ignored.
- All five requesters len=0 last=1 -> no fifo_w_en; blk_done in cycle 6; bit_count=0.
